axil_csr_responder: RTL and testbench
=====================================

Name: axil_csr_responder

Overview:
- AXI4-Lite slave register file that terminates the `s_axi_csrs_*` control interface of the RSA wrapper.
- Holds the six 32-bit control registers that software or the bench programs: COMMAND, RXADDR, TXADDR, T, T_LEN, LOADING.
- Returns the core STATUS word on reads of offset 0.
- Sits between the AXI-Lite interconnect and the RSA/Montgomery control FSM; drives that FSM's configuration inputs and a one-cycle COMMAND write strobe.

Parameters:
- ADDR_W, 12, AXI-Lite address width in bits.
- DATA_W, 32, data width; only 32 is supported.
- NUM_REGS, 6, number of implemented word registers at byte offsets 0,4,...,20.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, active-low
- s_axi_csrs_awaddr  in  ADDR_W  write address
- s_axi_csrs_awvalid  in  1  write address valid
- s_axi_csrs_awready  out  1  write address ready
- s_axi_csrs_wdata  in  32  write data
- s_axi_csrs_wstrb  in  4  byte enables
- s_axi_csrs_wvalid  in  1  write data valid
- s_axi_csrs_wready  out  1  write data ready
- s_axi_csrs_bresp  out  2  write response
- s_axi_csrs_bvalid  out  1  write response valid
- s_axi_csrs_bready  in  1  write response ready
- s_axi_csrs_araddr  in  ADDR_W  read address
- s_axi_csrs_arvalid  in  1  read address valid
- s_axi_csrs_arready  out  1  read address ready
- s_axi_csrs_rdata  out  32  read data
- s_axi_csrs_rresp  out  2  read response
- s_axi_csrs_rvalid  out  1  read data valid
- s_axi_csrs_rready  in  1  read data ready
- status_i  in  32  core status; bit0 = done
- command_o, rxaddr_o, txaddr_o, t_o, t_len_o, loading_o  out  32 each  register contents
- command_wr_o  out  1  one-cycle pulse on each committed COMMAND write

Behaviour:
Interface and reset:
- One clock, `clk`. Reset `resetn` is synchronous and active-low: all state updates on the rising edge of `clk` while resetn==0.
- In reset: all registers are 0; bvalid, rvalid and command_wr_o are 0; bresp, rresp and rdata are 0; the FSMs go to IDLE.
- Reset asserted mid-transaction abandons that transaction with no response.

Write path (states W_IDLE, W_RESP):
- awready = W_IDLE and no AW captured. wready = W_IDLE and no W captured. Both are combinational from registered state.
- AW and W handshakes are accepted independently, in either order or in the same cycle; address and data are captured into holding registers.
- Commit happens on the first edge at which both are captured (same edge as the second handshake when it completes via the ready path; otherwise the edge after):
  - the selected register is updated per byte lane where wstrb[i]=1;
  - bvalid is set;
  - the state moves to W_RESP.
- W_RESP: bvalid is held until bready. On the handshake, clear bvalid and the captured flags, and return to W_IDLE. awready and wready stay 0 throughout W_RESP.
- Decode: addr[ADDR_W-1:2] selects the word; addr[1:0] is ignored.
  - Word index < NUM_REGS: bresp=OKAY (00).
  - Otherwise: no register changes, bresp=SLVERR (10).
- command_wr_o pulses high for exactly the commit cycle when word 0 is written with OKAY, even if wstrb=0.

Read path (states R_IDLE, R_DATA):
- arready = R_IDLE.
- On AR handshake, rdata is registered at that edge, rvalid=1, and the state moves to R_DATA. This gives 1-cycle latency.
- Read data:
  - word 0 returns status_i, not the COMMAND register;
  - words 1..5 return register contents;
  - out-of-range returns 0 with rresp=SLVERR.
- R_DATA: rdata and rvalid are held stable until rready, then clear rvalid and return to R_IDLE.

Concurrency:
- Read and write paths are fully independent and may be active in the same cycle.
- Read and write commit to the same register on the same edge: the read returns the pre-write value.

Outputs and fixed responses:
- Register outputs are driven directly from flops; they change only on commit.
- No response ever returns DECERR or EXOKAY.

Decomposition:
- Shared package rsa_csr_pkg holds:
  - word offsets: COMMAND=0, RXADDR=1, TXADDR=2, T=3, T_LEN=4, LOADING=5 (byte offsets 0,4,8,12,16,20);
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - write/read FSM state enums.
- No sub-module. The byte-strobe merge is a small function in the package (merge(old,new,strb)).

Test Plan:
1. Reset, then idle: all *_o=0, bvalid=rvalid=0, awready=wready=arready=1.
2. Write TXADDR (0x008) = 0x00000180 with wstrb=F, AW and W together, bready=1: bresp=00, bvalid one cycle after commit, txaddr_o=0x180, command_wr_o stays 0.
3. W asserted 3 cycles before AW, LOADING(0x014)=0x9, wstrb=0b0001: commit only after AW; loading_o=0x00000009. Then write 0xFFFFFFFF with wstrb=0b0100: loading_o=0x00FF0009.
4. Write COMMAND=1: command_o=1 and command_wr_o high exactly one cycle. Read 0x000 with status_i=0x1: rdata=0x00000001 one cycle after AR; hold rready=0 for 4 cycles, rdata/rvalid stable.
5. Write 0x040=0xDEADBEEF: bresp=10, no *_o changes. Read 0x018: rresp=10, rdata=0.
6. T(0x00C)=0x9985 written while a read of 0x00C completes on the commit edge: read returns 0; next read returns 0x00009985. Then assert resetn=0 during W_RESP: all outputs return to reset values.

Source files
------------

// File: rtl/rsa_csr_pkg.sv
// Shared definitions for the RSA wrapper AXI-Lite CSR block:
// register word map, response codes, FSM state types, byte-lane merge.
package rsa_csr_pkg;

  localparam int unsigned REG_COMMAND = 0;
  localparam int unsigned REG_RXADDR  = 1;
  localparam int unsigned REG_TXADDR  = 2;
  localparam int unsigned REG_T       = 3;
  localparam int unsigned REG_T_LEN   = 4;
  localparam int unsigned REG_LOADING = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = nw[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_csr_responder.sv
// AXI4-Lite slave holding the RSA control registers; word 0 reads
// back the core status while writes to it pulse command_wr_o.
module axil_csr_responder
  import rsa_csr_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] s_axi_csrs_awaddr,
  input  logic              s_axi_csrs_awvalid,
  output logic              s_axi_csrs_awready,
  input  logic [DATA_W-1:0] s_axi_csrs_wdata,
  input  logic [3:0]        s_axi_csrs_wstrb,
  input  logic              s_axi_csrs_wvalid,
  output logic              s_axi_csrs_wready,
  output logic [1:0]        s_axi_csrs_bresp,
  output logic              s_axi_csrs_bvalid,
  input  logic              s_axi_csrs_bready,
  input  logic [ADDR_W-1:0] s_axi_csrs_araddr,
  input  logic              s_axi_csrs_arvalid,
  output logic              s_axi_csrs_arready,
  output logic [DATA_W-1:0] s_axi_csrs_rdata,
  output logic [1:0]        s_axi_csrs_rresp,
  output logic              s_axi_csrs_rvalid,
  input  logic              s_axi_csrs_rready,
  input  logic [DATA_W-1:0] status_i,
  output logic [DATA_W-1:0] command_o,
  output logic [DATA_W-1:0] rxaddr_o,
  output logic [DATA_W-1:0] txaddr_o,
  output logic [DATA_W-1:0] t_o,
  output logic [DATA_W-1:0] t_len_o,
  output logic [DATA_W-1:0] loading_o,
  output logic              command_wr_o
);

  localparam int IDX_W = ADDR_W - 2;

  wr_state_t wstate, wstate_nx;
  rd_state_t rstate, rstate_nx;

  logic              aw_got, w_got;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [3:0]        w_strb;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              aw_hs, w_hs, b_hs;
  logic              ar_hs, r_hs;
  logic              commit;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] c_data;
  logic [3:0]        c_strb;
  logic              c_hit;
  logic [IDX_W-1:0]  r_idx;
  logic              r_hit;
  logic [DATA_W-1:0] rd_word;
  logic [3:0]        addr_unused;

  assign addr_unused = {s_axi_csrs_awaddr[1:0], s_axi_csrs_araddr[1:0]};

  assign s_axi_csrs_awready = (wstate == W_IDLE) && !aw_got;
  assign s_axi_csrs_wready  = (wstate == W_IDLE) && !w_got;
  assign s_axi_csrs_arready = (rstate == R_IDLE);

  assign aw_hs = s_axi_csrs_awvalid && s_axi_csrs_awready;
  assign w_hs  = s_axi_csrs_wvalid && s_axi_csrs_wready;
  assign b_hs  = s_axi_csrs_bvalid && s_axi_csrs_bready;
  assign ar_hs = s_axi_csrs_arvalid && s_axi_csrs_arready;
  assign r_hs  = s_axi_csrs_rvalid && s_axi_csrs_rready;

  // Commit on the edge where the second half arrives, using the live
  // bus value for whichever half has not been captured yet.
  assign commit = (wstate == W_IDLE)
                && (aw_got || aw_hs)
                && (w_got || w_hs);
  assign c_idx  = aw_got ? aw_idx : s_axi_csrs_awaddr[ADDR_W-1:2];
  assign c_data = w_got ? w_data : s_axi_csrs_wdata;
  assign c_strb = w_got ? w_strb : s_axi_csrs_wstrb;
  assign c_hit  = c_idx < IDX_W'(NUM_REGS);

  assign r_idx = s_axi_csrs_araddr[ADDR_W-1:2];
  assign r_hit = r_idx < IDX_W'(NUM_REGS);

  always_comb begin
    rd_word = '0;
    if (r_idx == '0) begin
      rd_word = status_i;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (r_idx == IDX_W'(i)) rd_word = regs[i];
      end
    end
  end

  always_comb begin
    wstate_nx = wstate;
    unique case (wstate)
      W_IDLE: if (commit) wstate_nx = W_RESP;
      W_RESP: if (b_hs) wstate_nx = W_IDLE;
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_nx = rstate;
    unique case (rstate)
      R_IDLE: if (ar_hs) rstate_nx = R_DATA;
      R_DATA: if (r_hs) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nx;
      rstate <= rstate_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_got            <= 1'b0;
      w_got             <= 1'b0;
      aw_idx            <= '0;
      w_data            <= '0;
      w_strb            <= '0;
      s_axi_csrs_bvalid <= 1'b0;
      s_axi_csrs_bresp  <= RESP_OKAY;
      command_wr_o      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      command_wr_o <= 1'b0;
      if (aw_hs) begin
        aw_got <= 1'b1;
        aw_idx <= s_axi_csrs_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_got  <= 1'b1;
        w_data <= s_axi_csrs_wdata;
        w_strb <= s_axi_csrs_wstrb;
      end
      if (commit) begin
        aw_got            <= 1'b1;
        w_got             <= 1'b1;
        s_axi_csrs_bvalid <= 1'b1;
        s_axi_csrs_bresp  <= c_hit ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (c_hit && c_idx == IDX_W'(i))
            regs[i] <= merge(regs[i], c_data, c_strb);
        end
        // Strobe fires even for an all-zero wstrb
        if (c_idx == '0) command_wr_o <= 1'b1;
      end
      if (b_hs) begin
        s_axi_csrs_bvalid <= 1'b0;
        aw_got            <= 1'b0;
        w_got             <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_axi_csrs_rvalid <= 1'b0;
      s_axi_csrs_rdata  <= '0;
      s_axi_csrs_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_csrs_rvalid <= 1'b1;
      s_axi_csrs_rdata  <= rd_word;
      s_axi_csrs_rresp  <= r_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      s_axi_csrs_rvalid <= 1'b0;
    end
  end

  assign command_o = regs[REG_COMMAND];
  assign rxaddr_o  = regs[REG_RXADDR];
  assign txaddr_o  = regs[REG_TXADDR];
  assign t_o       = regs[REG_T];
  assign t_len_o   = regs[REG_T_LEN];
  assign loading_o = regs[REG_LOADING];

endmodule

// File: tb/tb_axil_csr_responder.sv
// Bench for axil_csr_responder: directed table, corner sequences,
// then random traffic against a word-array reference model.
module tb_axil_csr_responder;

  logic        clk = 0;
  logic        resetn = 0;
  logic [11:0] awaddr = 0;
  logic        awvalid = 0;
  logic        awready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wvalid = 0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1;
  logic [11:0] araddr = 0;
  logic        arvalid = 0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 0;
  logic [31:0] status = 0;
  logic [31:0] command, rxaddr, txaddr, t, t_len, loading;
  logic        command_wr;

  axil_csr_responder dut (
    .clk(clk), .resetn(resetn),
    .s_axi_csrs_awaddr(awaddr), .s_axi_csrs_awvalid(awvalid),
    .s_axi_csrs_awready(awready),
    .s_axi_csrs_wdata(wdata), .s_axi_csrs_wstrb(wstrb),
    .s_axi_csrs_wvalid(wvalid), .s_axi_csrs_wready(wready),
    .s_axi_csrs_bresp(bresp), .s_axi_csrs_bvalid(bvalid),
    .s_axi_csrs_bready(bready),
    .s_axi_csrs_araddr(araddr), .s_axi_csrs_arvalid(arvalid),
    .s_axi_csrs_arready(arready),
    .s_axi_csrs_rdata(rdata), .s_axi_csrs_rresp(rresp),
    .s_axi_csrs_rvalid(rvalid), .s_axi_csrs_rready(rready),
    .status_i(status),
    .command_o(command), .rxaddr_o(rxaddr), .txaddr_o(txaddr),
    .t_o(t), .t_len_o(t_len), .loading_o(loading),
    .command_wr_o(command_wr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cw_cnt = 0;
  logic [31:0] m [6];

  always @(negedge clk) if (command_wr) cw_cnt++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] out_of(input int i);
    case (i)
      0: return command;
      1: return rxaddr;
      2: return txaddr;
      3: return t;
      4: return t_len;
      5: return loading;
      default: return 32'hx;
    endcase
  endfunction

  task automatic chk_outs(input string name);
    for (int i = 0; i < 6; i++) chk(name, out_of(i), m[i]);
  endtask

  function automatic void model_wr(input logic [11:0] a,
                                   input logic [31:0] d,
                                   input logic [3:0] s,
                                   output logic [1:0] r);
    int w;
    w = int'(a) / 4;
    if (w >= 6) begin
      r = 2'b10;
      return;
    end
    r = 2'b00;
    for (int b = 0; b < 4; b++)
      if (s[b]) m[w][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic void model_rd(input logic [11:0] a,
                                   output logic [31:0] d,
                                   output logic [1:0] r);
    int w;
    w = int'(a) / 4;
    r = (w < 6) ? 2'b00 : 2'b10;
    d = (w == 0) ? status : (w < 6) ? m[w] : 32'h0;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the B handshake.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int awd,
                           input int wd, output logic [1:0] resp,
                           output bit ok);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    ok = 0;
    resp = 2'bxx;
    bready = 1;
    if (awd == 0) begin awaddr = a; awvalid = 1; end
    if (wd == 0) begin wdata = d; wstrb = s; wvalid = 1; end
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 0; aw_done = 1; end
      if (w_hs) begin wvalid = 0; w_done = 1; end
      cyc++;
      if (!aw_done && !awvalid && cyc >= awd) begin
        awaddr = a; awvalid = 1;
      end
      if (!w_done && !wvalid && cyc >= wd) begin
        wdata = d; wstrb = s; wvalid = 1;
      end
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bvalid) begin resp = bresp; ok = 1; end
      @(posedge clk); #1;
    end
    awvalid = 0;
    wvalid = 0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit ok);
    bit hs = 0;
    ok = 0;
    d = 'x;
    resp = 'x;
    araddr = a;
    arvalid = 1;
    rready = 1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 0;
    @(negedge clk);
    if (hs && rvalid) begin d = rdata; resp = rresp; ok = 1; end
    @(posedge clk); #1;
    rready = 0;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awd;
    int          wd;
    logic [1:0]  resp;
    int          ridx;
    logic [31:0] val;
    int          cw;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [1:0]  r, er;
    logic [31:0] d, ed;
    bit ok;
    int c0;

    vt[0] = '{12'h008, 32'h0000_0180, 4'hF, 0, 0, 2'b00, 2, 32'h0000_0180, 0};
    vt[1] = '{12'h014, 32'h0000_0009, 4'h1, 3, 0, 2'b00, 5, 32'h0000_0009, 0};
    vt[2] = '{12'h014, 32'hFFFF_FFFF, 4'h4, 0, 2, 2'b00, 5, 32'h00FF_0009, 0};
    vt[3] = '{12'h000, 32'h0000_0001, 4'hF, 1, 1, 2'b00, 0, 32'h0000_0001, 1};
    vt[4] = '{12'h040, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b10, 5, 32'h00FF_0009, 0};
    vt[5] = '{12'h003, 32'h0000_FFFF, 4'h0, 2, 0, 2'b00, 0, 32'h0000_0001, 1};
    for (int i = 0; i < 6; i++) m[i] = 0;

    repeat (3) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    chk_outs("reset_out");
    chk("reset_bvalid", {31'b0, bvalid}, 0);
    chk("reset_rvalid", {31'b0, rvalid}, 0);
    chk("reset_ready", {29'b0, awready, wready, arready}, 3'b111);
    chk("reset_cw", {31'b0, command_wr}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      c0 = cw_cnt;
      axi_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].awd, vt[i].wd,
                r, ok);
      model_wr(vt[i].addr, vt[i].data, vt[i].strb, er);
      chk($sformatf("vec%0d_done", i), {31'b0, ok}, 1);
      chk($sformatf("vec%0d_bresp", i), {30'b0, r}, {30'b0, vt[i].resp});
      chk($sformatf("vec%0d_reg", i), out_of(vt[i].ridx), vt[i].val);
      chk($sformatf("vec%0d_cw", i), cw_cnt - c0, vt[i].cw);
      chk_outs($sformatf("vec%0d_outs", i));
    end

    // Status read with rready held low: data must stay put
    status = 32'h1;
    araddr = 12'h000;
    arvalid = 1;
    rready = 0;
    @(posedge clk); #1;
    arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_rvalid", {31'b0, rvalid}, 1);
      chk("hold_rdata", rdata, 32'h1);
      @(posedge clk); #1;
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    chk("hold_release", {31'b0, rvalid}, 0);
    @(posedge clk); #1;

    axi_read(12'h018, d, r, ok);
    chk("oor_rd_ok", {31'b0, ok}, 1);
    chk("oor_rdata", d, 0);
    chk("oor_rresp", {30'b0, r}, 2'b10);

    // T written on the same edge a read of T is accepted
    bready = 0;
    awaddr = 12'h00C; wdata = 32'h9985; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    araddr = 12'h00C; arvalid = 1; rready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    m[3] = 32'h9985;
    @(negedge clk);
    chk("race_rvalid", {31'b0, rvalid}, 1);
    chk("race_rdata", rdata, 0);
    chk("race_bvalid", {31'b0, bvalid}, 1);
    chk("race_t", t, 32'h9985);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    rready = 0;
    axi_read(12'h00C, d, r, ok);
    chk("race_reread", d, 32'h9985);

    // Reset while a response is pending
    bready = 0;
    awaddr = 12'h004; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("pre_rst_bvalid", {31'b0, bvalid}, 1);
    resetn = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1;
    bready = 1;
    for (int i = 0; i < 6; i++) m[i] = 0;
    @(negedge clk);
    chk("rst_bvalid", {31'b0, bvalid}, 0);
    chk("rst_ready", {29'b0, awready, wready, arready}, 3'b111);
    chk_outs("rst_outs");
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      logic [31:0] dd;
      logic [3:0]  s;
      a = 12'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      dd = $urandom;
      s = 4'($urandom_range(0, 15));
      status = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        c0 = cw_cnt;
        axi_write(a, dd, s, $urandom_range(0, 3), $urandom_range(0, 3),
                  r, ok);
        model_wr(a, dd, s, er);
        chk("rnd_wdone", {31'b0, ok}, 1);
        chk("rnd_bresp", {30'b0, r}, {30'b0, er});
        chk("rnd_cw", cw_cnt - c0, (a < 12'h004) ? 1 : 0);
        chk_outs("rnd_outs");
      end else begin
        model_rd(a, ed, er);
        axi_read(a, d, r, ok);
        chk("rnd_rdone", {31'b0, ok}, 1);
        chk("rnd_rdata", d, ed);
        chk("rnd_rresp", {30'b0, r}, {30'b0, er});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
